// File: rtl/ysyx_25030093_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter:
// access sizes, FSM states, requester ids and the latched request bundle.
package ysyx_25030093_mem_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IFU = 2'd1,
        GRANT_LSU = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

endpackage

// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Request/response bundle used by the IFU, the LSU and the memory port.
// reqValid is held by the issuer until a single respValid pulse comes back.
interface ysyx_25030093_mem_arbiter_if;

    logic        reqValid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        respValid;
    logic [31:0] rdata;
    logic        err;

    // Issuer of requests; memory never reports err, so it is not part of this view.
    modport master (
        output reqValid, addr, size, wen, wdata, wmask,
        input  respValid, rdata
    );

    // Answering side, which may flag a timeout through err.
    modport slave (
        input  reqValid, addr, size, wen, wdata, wmask,
        output respValid, rdata, err
    );

endinterface

// File: rtl/ysyx_25030093_mem_arbiter_pick.sv
// Combinational grant select between IFU and LSU.
// Fixed priority favours the LSU; round robin hands contention to the other side.
module ysyx_25030093_arb_pick
    import ysyx_25030093_mem_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic    ifu_valid,
    input  logic    lsu_valid,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

    req_id_t rr_id;

    // Pick the winner for the current IDLE cycle.
    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        rr_id       = (last_grant == REQ_IFU) ? REQ_LSU : REQ_IFU;
        grant_id    = REQ_IFU;
        unique case ({ifu_valid, lsu_valid})
            2'b11:   grant_id = ROUND_ROBIN ? rr_id : REQ_LSU;
            2'b01:   grant_id = REQ_LSU;
            default: grant_id = REQ_IFU;
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Shares the single memory port between IFU and LSU: one grant at a time,
// latched downstream request, routed response and a timeout error path.
module ysyx_25030093_mem_arbiter
    import ysyx_25030093_mem_arbiter_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b0,
    parameter int unsigned TIMEOUT     = 1024,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input logic                         clock,
    input logic                         reset,
    ysyx_25030093_mem_arbiter_if.slave  ifu,
    ysyx_25030093_mem_arbiter_if.slave  lsu,
    ysyx_25030093_mem_arbiter_if.master mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    // Count value seen on the last GRANT cycle before giving up.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    req_id_t          last_grant;
    req_id_t          pick_id;
    logic             pick_valid;
    mem_req_t         ifu_req;
    mem_req_t         lsu_req;
    mem_req_t         req_q;
    logic             req_valid_q;
    logic [CNT_W-1:0] cnt;
    logic             granted;
    logic             timeout_hit;
    logic             resp_ok;
    logic             resp_to;
    logic             resp_fire;
    logic [31:0]      resp_rdata;
    logic             load;
    logic             finish;

    assign ifu_req = '{
        addr:  ifu.addr,
        size:  ifu.size,
        wen:   ifu.wen,
        wdata: ifu.wdata,
        wmask: ifu.wmask
    };

    assign lsu_req = '{
        addr:  lsu.addr,
        size:  lsu.size,
        wen:   lsu.wen,
        wdata: lsu.wdata,
        wmask: lsu.wmask
    };

    ysyx_25030093_arb_pick #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .ifu_valid   (ifu.reqValid),
        .lsu_valid   (lsu.reqValid),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    // Response qualification: a memory answer always beats a timeout in the same cycle.
    always_comb begin
        granted     = (state == GRANT_IFU) || (state == GRANT_LSU);
        timeout_hit = TO_EN && (cnt == CNT_LAST);
        resp_ok     = granted && mem.respValid;
        resp_to     = granted && timeout_hit && !mem.respValid;
        resp_fire   = resp_ok || resp_to;
        resp_rdata  = resp_ok ? mem.rdata : (resp_to ? ERR_DATA : 32'h0);
    end

    // State register; reset drops any outstanding grant immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the load/finish strobes for the datapath.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    load       = 1'b1;
                    next_state = (pick_id == REQ_LSU) ? GRANT_LSU : GRANT_IFU;
                end
            end
            GRANT_IFU, GRANT_LSU: begin
                if (resp_fire) begin
                    finish     = 1'b1;
                    next_state = RELEASE;
                end
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch, downstream valid, timeout counter and grant history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            req_valid_q <= 1'b0;
            cnt         <= '0;
            last_grant  <= REQ_IFU;
        end else if (load) begin
            req_q       <= (pick_id == REQ_LSU) ? lsu_req : ifu_req;
            req_valid_q <= 1'b1;
            cnt         <= '0;
            last_grant  <= pick_id;
        end else if (finish) begin
            req_valid_q <= 1'b0;
        end else if (granted) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign mem.reqValid = req_valid_q;
    assign mem.addr     = req_q.addr;
    assign mem.size     = req_q.size;
    assign mem.wen      = req_q.wen;
    assign mem.wdata    = req_q.wdata;
    assign mem.wmask    = req_q.wmask;

    // Route the response to the granted requester only; the other sees zeros.
    always_comb begin
        ifu.respValid = 1'b0;
        ifu.rdata     = 32'h0;
        ifu.err       = 1'b0;
        lsu.respValid = 1'b0;
        lsu.rdata     = 32'h0;
        lsu.err       = 1'b0;
        unique case (1'b1)
            (state == GRANT_IFU): begin
                ifu.respValid = resp_fire;
                ifu.rdata     = resp_rdata;
                ifu.err       = resp_to;
            end
            (state == GRANT_LSU): begin
                lsu.respValid = resp_fire;
                lsu.rdata     = resp_rdata;
                lsu.err       = resp_to;
            end
            default: ;
        endcase
    end

endmodule
